// File: rtl/filter_cfg_pkg.sv
// Shared constants and types for the filter configuration controller:
// register addresses, CTRL field layout, filter type codes and FSM states.
package filter_cfg_pkg;

  localparam logic [3:0] ADDR_INT_STATUS  = 4'd8;
  localparam logic [3:0] ADDR_DATA_STATUS = 4'd9;

  localparam int CTRL_TYPE_LSB = 0;
  localparam int CTRL_TYPE_W   = 2;
  localparam int CTRL_WIN_LSB  = 2;
  localparam int CTRL_WIN_W    = 4;
  localparam int CTRL_IEN_BIT  = 6;

  typedef enum logic [1:0] {
    FT_OFF  = 2'b00,
    FT_RISE = 2'b01,
    FT_FALL = 2'b10,
    FT_BOTH = 2'b11
  } ftype_e;

  // Field order mirrors the CTRL register bit layout (bit 7 reserved).
  typedef struct packed {
    logic                  ien;
    logic [CTRL_WIN_W-1:0] win;
    ftype_e                ftype;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_FLUSH,
    ST_APPLY
  } state_e;

endpackage

// File: rtl/filter_irq_status.sv
// Sticky per-channel interrupt status with write-1-to-clear and a
// registered aggregated interrupt that lags the status bits by one cycle.
module filter_irq_status #(
  parameter int NUM_CH = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NUM_CH-1:0] ch_int,
  input  logic [NUM_CH-1:0] clr,
  output logic [NUM_CH-1:0] status,
  output logic              irq
);

  // A new pulse outranks a clear landing in the same cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      status <= '0;
      irq    <= 1'b0;
    end else begin
      status <= ch_int | (status & ~clr);
      irq    <= |status;
    end
  end

endmodule

// File: rtl/filter_cfg_ctrl.sv
// Register interface, reconfiguration sequencer and CTRL bank for NUM_CH
// filter channels; active channels are flushed before new settings apply.
module filter_cfg_ctrl
  import filter_cfg_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [3:0]          addr_i,
  input  logic [7:0]          wdata_i,
  output logic                ack_o,
  output logic [7:0]          rdata_o,
  output logic                busy_o,
  output logic [2*NUM_CH-1:0] filter_type_o,
  output logic [4*NUM_CH-1:0] window_size_o,
  output logic [NUM_CH-1:0]   int_en_o,
  input  logic [NUM_CH-1:0]   ch_int_i,
  input  logic [NUM_CH-1:0]   ch_data_i,
  output logic                irq_o
);

  state_e            state_q, state_d;
  ctrl_t             ctrl_q [NUM_CH];
  ctrl_t             shadow_q, cur_ctrl, new_ctrl;
  logic [2:0]        tgt_q;
  logic [3:0]        cnt_q;
  logic [NUM_CH-1:0] w1c_q, clr, status;
  logic [7:0]        rdata_q, rd_val;
  logic              accept, is_ctrl, need_flush;
  logic              unused_wdata;

  assign unused_wdata = wdata_i[7];
  assign accept       = req_i && (state_q == ST_IDLE);

  // NOTE: every signal gets a default before any branch so no path infers a latch.
  always_comb begin
    cur_ctrl = '0;
    rd_val   = 8'h00;
    for (int n = 0; n < NUM_CH; n++) begin
      if (addr_i == 4'(n)) cur_ctrl = ctrl_q[n];
    end
    is_ctrl = (addr_i < 4'(NUM_CH));
    if (is_ctrl)                           rd_val = {1'b0, cur_ctrl};
    else if (addr_i == ADDR_INT_STATUS)    rd_val = 8'(status);
    else if (addr_i == ADDR_DATA_STATUS)   rd_val = 8'(ch_data_i);

    new_ctrl       = '0;
    new_ctrl.ftype = ftype_e'(wdata_i[CTRL_TYPE_LSB +: CTRL_TYPE_W]);
    new_ctrl.win   = wdata_i[CTRL_WIN_LSB +: CTRL_WIN_W];
    new_ctrl.ien   = wdata_i[CTRL_IEN_BIT];

    // Only a running channel whose type or window changes must be flushed.
    need_flush = we_i && is_ctrl && (cur_ctrl.ftype != FT_OFF) &&
                 ((new_ctrl.ftype != cur_ctrl.ftype) || (new_ctrl.win != cur_ctrl.win));
  end

  always_comb begin
    state_d = state_q;
    ack_o   = 1'b0;
    busy_o  = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = need_flush ? ST_FLUSH : ST_ACCESS;
      ST_ACCESS: begin
        ack_o   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FLUSH:  if (cnt_q == '0) state_d = ST_APPLY;
      ST_APPLY: begin
        ack_o   = 1'b1;
        state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: flops use non-blocking assignment so each register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: the CTRL bank is a few flops rather than a RAM, so it is reset like all other state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int n = 0; n < NUM_CH; n++) ctrl_q[n] <= '0;
      shadow_q <= '0;
      tgt_q    <= '0;
      cnt_q    <= '0;
      w1c_q    <= '0;
      rdata_q  <= '0;
    end else if (accept) begin
      rdata_q  <= we_i ? 8'h00 : rd_val;
      w1c_q    <= (we_i && addr_i == ADDR_INT_STATUS) ? wdata_i[NUM_CH-1:0] : '0;
      shadow_q <= new_ctrl;
      tgt_q    <= addr_i[2:0];
      cnt_q    <= 4'(FLUSH_CYC - 1);
      for (int n = 0; n < NUM_CH; n++) begin
        if (we_i && !need_flush && addr_i == 4'(n)) ctrl_q[n] <= new_ctrl;
      end
    end else if (state_q == ST_FLUSH) begin
      // The shadow lands on the last flush edge so it is live during APPLY.
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end else begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (tgt_q == 3'(n)) ctrl_q[n] <= shadow_q;
        end
      end
    end
  end

  always_comb begin
    filter_type_o = '0;
    window_size_o = '0;
    int_en_o      = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      filter_type_o[2*n +: 2] = (state_q == ST_FLUSH && tgt_q == 3'(n)) ? FT_OFF : ctrl_q[n].ftype;
      window_size_o[4*n +: 4] = ctrl_q[n].win;
      int_en_o[n]             = ctrl_q[n].ien;
    end
  end

  assign rdata_o = ack_o ? rdata_q : 8'h00;
  assign clr     = (state_q == ST_ACCESS) ? w1c_q : '0;

  filter_irq_status #(
    .NUM_CH (NUM_CH)
  ) u_irq_status (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .ch_int (ch_int_i),
    .clr    (clr),
    .status (status),
    .irq    (irq_o)
  );

endmodule

// File: tb/tb_filter_cfg_ctrl.sv
// Self-checking bench for filter_cfg_ctrl: table-driven register accesses with
// a scoreboard for ack timing/read data, plus hand-written corner sequences.
module tb_filter_cfg_ctrl;

  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rstn, req, we;
  logic [3:0]        addr;
  logic [7:0]        wdata, rdata;
  logic              ack, busy, irq;
  logic [2*NUM_CH-1:0] filter_type;
  logic [4*NUM_CH-1:0] window_size;
  logic [NUM_CH-1:0] int_en, ch_int, ch_data;

  always #5 clk = ~clk;

  filter_cfg_ctrl #(.NUM_CH(NUM_CH), .FLUSH_CYC(2)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .req_i         (req),
    .we_i          (we),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .ack_o         (ack),
    .rdata_o       (rdata),
    .busy_o        (busy),
    .filter_type_o (filter_type),
    .window_size_o (window_size),
    .int_en_o      (int_en),
    .ch_int_i      (ch_int),
    .ch_data_i     (ch_data),
    .irq_o         (irq)
  );

  typedef struct {
    int         ack_at;
    logic [7:0] rd;
  } exp_t;

  typedef struct {
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
    int         lat;
    logic [7:0] rd;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_cnt = 0;

  always @(posedge clk) cyc_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every ack pops one expectation; cycle of arrival and read data are both checked.
  always @(negedge clk) begin
    if (rstn && ack) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", ack, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        check("ack_cycle", cyc_cnt, mon_e.ack_at);
        check("rdata", rdata, mon_e.rd);
      end
    end else if (rstn) begin
      check("rdata_idle", rdata, 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d,
                       input int lat, input logic [7:0] rd);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    sb_q.push_back('{ack_at: cyc_cnt + lat, rd: rd});
    tick();
    req   = 1'b0;
    we    = 1'b0;
    addr  = 4'h0;
    wdata = 8'h00;
  endtask

  task automatic xact(input logic w, input logic [3:0] a, input logic [7:0] d,
                      input int lat, input logic [7:0] rd);
    issue(w, a, d, lat, rd);
    repeat (lat) tick();
  endtask

  initial begin
    rstn    = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    addr    = 4'h0;
    wdata   = 8'h00;
    ch_int  = '0;
    ch_data = 4'hA;
    repeat (2) tick();
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_type", filter_type, 0);
    check("rst_window", window_size, 0);
    check("rst_int_en", int_en, 0);
    check("rst_irq", irq, 0);
    rstn = 1'b1;
    tick();

    // Reads of the whole map, then CTRL writes on the fast path and one flush.
    for (int a = 0; a < 16; a++)
      vecs.push_back('{w: 1'b0, a: 4'(a), d: 8'h00, lat: 1, rd: (a == 9) ? 8'h0A : 8'h00});
    vecs.push_back('{w: 1'b1, a: 4'd0,  d: 8'h7F, lat: 1, rd: 8'h00});
    vecs.push_back('{w: 1'b0, a: 4'd0,  d: 8'h00, lat: 1, rd: 8'h7F});
    vecs.push_back('{w: 1'b1, a: 4'd3,  d: 8'hFF, lat: 1, rd: 8'h00});
    vecs.push_back('{w: 1'b0, a: 4'd3,  d: 8'h00, lat: 1, rd: 8'h7F});
    vecs.push_back('{w: 1'b1, a: 4'd12, d: 8'h55, lat: 1, rd: 8'h00});
    vecs.push_back('{w: 1'b0, a: 4'd12, d: 8'h00, lat: 1, rd: 8'h00});
    vecs.push_back('{w: 1'b1, a: 4'd9,  d: 8'hFF, lat: 1, rd: 8'h00});
    vecs.push_back('{w: 1'b1, a: 4'd0,  d: 8'h7F, lat: 1, rd: 8'h00});
    vecs.push_back('{w: 1'b1, a: 4'd0,  d: 8'h3F, lat: 1, rd: 8'h00});
    vecs.push_back('{w: 1'b1, a: 4'd3,  d: 8'h03, lat: 3, rd: 8'h00});
    vecs.push_back('{w: 1'b0, a: 4'd3,  d: 8'h00, lat: 1, rd: 8'h03});
    vecs.push_back('{w: 1'b0, a: 4'd0,  d: 8'h00, lat: 1, rd: 8'h3F});
    foreach (vecs[i]) xact(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].lat, vecs[i].rd);
    check("tbl_type", filter_type, 8'hC3);
    check("tbl_window", window_size, 16'h000F);
    check("tbl_int_en", int_en, 4'h0);

    // CTRL_1 = 0x4D while channel 1 is off: applied at T+1.
    issue(1'b1, 4'd1, 8'h4D, 1, 8'h00);
    check("fast_type", filter_type, 8'hC7);
    check("fast_window", window_size, 16'h003F);
    check("fast_int_en", int_en, 4'h2);
    tick();

    // CTRL_1 = 0x52 while active: flushed for two cycles, ack at T+3.
    issue(1'b1, 4'd1, 8'h52, 3, 8'h00);
    check("flush1_type", filter_type, 8'hC3);
    check("flush1_window", window_size, 16'h003F);
    check("flush1_busy", busy, 1);
    tick();
    check("flush2_type", filter_type, 8'hC3);
    req  = 1'b1;
    we   = 1'b0;
    addr = 4'd0;
    tick();
    req  = 1'b0;
    check("apply_type", filter_type, 8'hCB);
    check("apply_window", window_size, 16'h004F);
    check("apply_int_en", int_en, 4'h2);
    check("apply_ack", ack, 1);
    tick();
    check("post_apply_busy", busy, 0);
    repeat (3) tick();
    check("dropped_req_ack", ack, 0);

    // Sticky status bit 2, readback, W1C, irq lag.
    ch_int = 4'b0100;
    tick();
    ch_int = '0;
    check("irq_lag", irq, 0);
    tick();
    check("irq_set", irq, 1);
    xact(1'b0, 4'd8, 8'h00, 1, 8'h04);
    xact(1'b1, 4'd8, 8'h04, 1, 8'h00);
    check("irq_after_w1c", irq, 1);
    tick();
    check("irq_cleared", irq, 0);
    xact(1'b0, 4'd8, 8'h00, 1, 8'h00);

    // New pulse on bit 0 in the cycle its W1C completes: set wins.
    ch_int = 4'b0001;
    tick();
    ch_int = '0;
    tick();
    check("irq_bit0", irq, 1);
    issue(1'b1, 4'd8, 8'h01, 1, 8'h00);
    ch_int = 4'b0001;
    tick();
    ch_int = '0;
    check("set_wins_irq1", irq, 1);
    tick();
    check("set_wins_irq2", irq, 1);
    xact(1'b0, 4'd8, 8'h00, 1, 8'h01);
    xact(1'b1, 4'd8, 8'h01, 1, 8'h00);
    tick();
    check("irq_bit0_cleared", irq, 0);

    // Reset during FLUSH aborts the write with no ack.
    issue(1'b1, 4'd1, 8'h41, 3, 8'h00);
    check("abort_flush_type", filter_type, 8'hC3);
    tick();
    rstn = 1'b0;
    sb_q.delete();
    #1;
    check("abort_ack", ack, 0);
    check("abort_busy", busy, 0);
    check("abort_type", filter_type, 0);
    check("abort_window", window_size, 0);
    check("abort_int_en", int_en, 0);
    check("abort_irq", irq, 0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (3) tick();
    xact(1'b0, 4'd1, 8'h00, 1, 8'h00);
    check("post_rst_type", filter_type, 0);

    repeat (2) tick();
    check("sb_pending", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/filter_cfg_ctrl.md
Name: filter_cfg_ctrl

Overview:
- Configuration and interrupt controller for a bank of NUM_CH filter channels.
- Holds the per-channel FILTER_CTRL fields (type, window size, interrupt enable) behind a simple single-master register interface.
- Sequences safe reconfiguration: an active channel is forced to "disabled" for FLUSH_CYC cycles before new settings apply, which clears its window counter.
- Collects the channels' single-cycle interrupt pulses into a sticky write-1-to-clear status register and drives one aggregated irq.

Parameters:
- NUM_CH, 4: number of filter channels (1..8).
- FLUSH_CYC, 2: cycles the filter type is held at 00 during reconfiguration (1..15).

Ports:
- clk_i, input, 1: system clock.
- rstn_i, input, 1: reset, asynchronous, active-low.
- req_i, input, 1: single-cycle transaction request pulse.
- we_i, input, 1: 1 = write, 0 = read; sampled with req_i.
- addr_i, input, 4: register address; sampled with req_i.
- wdata_i, input, 8: write data; sampled with req_i.
- ack_o, output, 1: single-cycle transaction completion pulse.
- rdata_o, output, 8: read data; valid only while ack_o is high, 0 otherwise.
- busy_o, output, 1: high while a transaction is in progress.
- filter_type_o, output, 2*NUM_CH: per-channel filter type. Channel n uses bits [2n+1:2n]. 00 = off, 01 = rise, 10 = fall, 11 = both.
- window_size_o, output, 4*NUM_CH: per-channel window code. Channel n uses bits [4n+3:4n].
- int_en_o, output, NUM_CH: per-channel interrupt enable.
- ch_int_i, input, NUM_CH: per-channel interrupt pulses from the filters.
- ch_data_i, input, NUM_CH: per-channel filtered outputs, for status readback.
- irq_o, output, 1: registered OR of all INT_STATUS bits.

Behaviour:
- Reset: all outputs 0, all registers 0, FSM in IDLE. Reset asserted mid-transaction aborts it and no ack is issued.
- Register map:
  - 0..NUM_CH-1: CTRL_n, read/write. Bits [1:0] type, [5:2] window, [6] int_en, [7] reserved (reads 0).
  - 8: INT_STATUS. Bits [NUM_CH-1:0] are sticky; writing 1 to a bit clears it.
  - 9: DATA_STATUS, read-only. Returns ch_data_i as sampled in the request cycle.
  - Any other address: read returns 0, write is ignored, ack is issued normally.
- Handshake:
  - A request is accepted only when req_i is high and the FSM is in IDLE.
  - req_i pulses while busy_o is high are dropped silently and not queued.
  - busy_o is high from the cycle after acceptance through the ack cycle inclusive.
- FSM states: IDLE, ACCESS, FLUSH, APPLY.
  - IDLE -> ACCESS on any accepted read, on any write to a non-CTRL address, or on a CTRL write that needs no flush.
  - IDLE -> FLUSH on a CTRL write that needs a flush.
  - ACCESS -> IDLE: ack_o pulses in ACCESS. Latency is 1 cycle (request at T, ack at T+1).
  - FLUSH: lasts FLUSH_CYC cycles; the target channel's filter_type_o is forced to 00. FLUSH -> APPLY.
  - APPLY -> IDLE: the shadow value is copied to the active outputs and ack_o pulses in the same cycle. Latency is FLUSH_CYC+1 (ack at T+3 with the default).
- Flush condition: the current active type is not 00, AND the type or window field changes.
  - A write that changes only int_en, a write of an identical value, or a write to a channel whose type is 00 takes the ACCESS path.
  - On the ACCESS path the new value is visible on the outputs at T+1.
- During FLUSH/APPLY, only the target channel is affected. A CTRL_n readback returns the active (pre-write) value until APPLY.
- INT_STATUS update, per bit and per cycle: set if ch_int_i[n] is high; else clear if a W1C with bit n = 1 completes this cycle; else hold.
  - Set and clear on the same cycle: set wins.
  - Interrupts are captured in every FSM state, including FLUSH.
  - The controller does not gate ch_int_i by int_en_o; that gating is done in the channel.
- irq_o is registered and equals the OR of INT_STATUS, lagging the status bits by one cycle.
- rdata_o for INT_STATUS and CTRL reads reflects register contents at the request cycle T.

Decomposition:
- Package filter_cfg_pkg holds:
  - Address constants ADDR_INT_STATUS = 8, ADDR_DATA_STATUS = 9.
  - CTRL field offsets and widths.
  - Filter type encodings FT_OFF, FT_RISE, FT_FALL, FT_BOTH.
  - FSM state enum.
- One sub-module, filter_irq_status, implements the sticky/W1C status bits and the irq_o register. The FSM and register file remain in the top level.

Test Plan:
- Reset, then read each address 0..15 -> every ack at T+1; rdata 0 everywhere except DATA_STATUS, which equals ch_data_i.
- Write CTRL_1 = 0x4D while channel 1 is off -> ack at T+1; filter_type_o[3:2] = 01, window_size_o[7:4] = 3, int_en_o[1] = 1 at T+1.
- Write CTRL_1 = 0x52 while channel 1 is active -> filter_type_o[3:2] = 00 at T+1 and T+2; new values (type 10, window 4, int_en 1) and ack at T+3. A req_i pulse at T+2 receives no ack.
- Pulse ch_int_i[2] -> INT_STATUS bit 2 set next cycle, irq_o high one cycle later. Write 0x04 to address 8 -> bit 2 clears, then irq_o drops.
- ch_int_i[0] pulse in the same cycle as a W1C of bit 0 completes -> bit 0 remains 1 and irq_o stays high.
- Assert rstn_i during FLUSH -> no ack; all outputs 0. After release, a CTRL read returns 0 with ack at T+1.
